// File: rtl/sccb_pkg.sv
// Shared constants for the SCCB responder: bus IDs, ACK/NA levels, FSM encoding.
package sccb_pkg;

    localparam logic [7:0] SCCB_WR_ID          = 8'h42;
    localparam logic [7:0] SCCB_RD_ID          = 8'h43;
    localparam logic       SCCB_ACK            = 1'b0;
    localparam logic       SCCB_NA             = 1'b1;
    localparam int         SCCB_MIN_OVERSAMPLE = 16;
    localparam int         SCCB_MIN_SYNC       = 2;

    typedef logic [3:0] sccb_state_t;

    localparam sccb_state_t ST_IDLE      = 4'd0;
    localparam sccb_state_t ST_ID        = 4'd1;
    localparam sccb_state_t ST_ID_ACK    = 4'd2;
    localparam sccb_state_t ST_ADDR      = 4'd3;
    localparam sccb_state_t ST_ADDR_ACK  = 4'd4;
    localparam sccb_state_t ST_WDATA     = 4'd5;
    localparam sccb_state_t ST_WDATA_ACK = 4'd6;
    localparam sccb_state_t ST_RDATA     = 4'd7;
    localparam sccb_state_t ST_RD_NA     = 4'd8;
    localparam sccb_state_t ST_IGNORE    = 4'd9;

endpackage

// File: rtl/sccb_line_sync.sv
// SCL/SDA synchronizer and bus-event detector (edges, START, STOP).
module sccb_line_sync
    import sccb_pkg::*;
#(
    parameter int STAGES = SCCB_MIN_SYNC
) (
    input  logic clk,
    input  logic rstn,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o,
    output logic sda_sync_o
);

    logic [STAGES-1:0] scl_sync_q, sda_sync_q;
    logic              scl_prev_q, sda_prev_q;
    logic              scl_s, sda_s;

    assign scl_s = scl_sync_q[STAGES-1];
    assign sda_s = sda_sync_q[STAGES-1];

    // Idle bus is high on both lines, so reset to 1 to avoid a phantom START.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_rise_o  = scl_s & ~scl_prev_q;
    assign scl_fall_o  = ~scl_s & scl_prev_q;
    assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign sda_sync_o  = sda_s;

endmodule

// File: rtl/sccb_slave_regfile.sv
// SCCB responder with a 256x8 register file: 3-phase writes, 2-phase reads,
// write strobe port and a registered debug read port.
module sccb_slave_regfile
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID      = SCCB_WR_ID,
    parameter int         SYNC_STAGES = 2,
    parameter bit         ACK_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl,
    inout  wire        sda,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       busy
);

    localparam logic [7:0] RD_ID = DEV_ID | 8'h01;

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    sccb_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rstn       (rstn),
        .scl_i      (scl),
        .sda_i      (sda),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_det_o(start_det),
        .stop_det_o (stop_det),
        .sda_sync_o (sda_s)
    );

    logic [7:0]  mem [256];
    sccb_state_t state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        oe_q, oe_d;
    logic        phase_q, phase_d;
    logic        rd_dir_q, rd_dir_d;
    logic        wr_valid_q, wr_valid_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  dbg_data_q;
    logic [7:0]  byte_in, mem_rd;
    logic        mem_we;

    assign byte_in = {shreg_q[6:0], sda_s};
    assign mem_rd  = mem[ptr_q];

    // phase_q: in ACK states, set once SDA is being held for the 9th bit;
    // in RD_NA, set once the master ACKed and a reload is pending.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        ptr_d      = ptr_q;
        oe_d       = oe_q;
        phase_d    = phase_q;
        rd_dir_d   = rd_dir_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_we     = 1'b0;
        if (start_det) begin
            state_d  = ST_ID;
            bitcnt_d = 3'd0;
            oe_d     = 1'b0;
            phase_d  = 1'b0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                ST_ID, ST_ADDR, ST_WDATA: begin
                    if (scl_rise) begin
                        shreg_d  = byte_in;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            if (state_q == ST_ID) begin
                                if (byte_in == DEV_ID) begin
                                    state_d  = ST_ID_ACK;
                                    rd_dir_d = 1'b0;
                                end else if (byte_in == RD_ID) begin
                                    state_d  = ST_ID_ACK;
                                    rd_dir_d = 1'b1;
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end else if (state_q == ST_ADDR) begin
                                ptr_d   = byte_in;
                                state_d = ST_ADDR_ACK;
                            end else begin
                                mem_we     = 1'b1;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = byte_in;
                                ptr_d      = ptr_q + 8'd1;
                                state_d    = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                ST_ID_ACK, ST_ADDR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            phase_d = 1'b1;
                            oe_d    = ACK_EN;
                        end else begin
                            phase_d  = 1'b0;
                            oe_d     = 1'b0;
                            bitcnt_d = 3'd0;
                            if (state_q == ST_ID_ACK && rd_dir_q) begin
                                state_d = ST_RDATA;
                                shreg_d = mem_rd;
                                oe_d    = ~mem_rd[7];
                            end else if (state_q == ST_ID_ACK) begin
                                state_d = ST_ADDR;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 3'd7) begin
                            oe_d    = 1'b0;
                            phase_d = 1'b0;
                            state_d = ST_RD_NA;
                        end else begin
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            oe_d     = ~shreg_q[6];
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                end
                ST_RD_NA: begin
                    if (scl_rise && !phase_q) begin
                        if (sda_s == SCCB_NA) begin
                            state_d = ST_IGNORE;
                        end else begin
                            ptr_d   = ptr_q + 8'd1;
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d  = 1'b0;
                        state_d  = ST_RDATA;
                        bitcnt_d = 3'd0;
                        shreg_d  = mem_rd;
                        oe_d     = ~mem_rd[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= 3'd0;
            shreg_q    <= 8'h00;
            ptr_q      <= 8'h00;
            oe_q       <= 1'b0;
            phase_q    <= 1'b0;
            rd_dir_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            dbg_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            phase_q    <= phase_d;
            rd_dir_q   <= rd_dir_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            dbg_data_q <= mem[dbg_addr];
        end
    end

    // Register file has no reset; a same-cycle debug read sees the old value.
    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr_q] <= byte_in;
    end

    // Gate with rstn so the line is released the instant reset asserts.
    assign sda      = (oe_q && rstn) ? 1'b0 : 1'bz;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign dbg_data = dbg_data_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Directed bench: bit-banged SCCB master against sccb_slave_regfile.
module tb_sccb_slave_regfile;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic       wr_valid;
    logic [7:0] wr_addr, wr_data;
    logic [7:0] dbg_addr = 8'h00;
    logic [7:0] dbg_data;
    logic       busy;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    sccb_slave_regfile dut (
        .clk     (clk),
        .rstn    (rstn),
        .scl     (scl),
        .sda     (sda),
        .wr_valid(wr_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int         nvec = 0;
    int         nerr = 0;
    int         qtr  = 250;
    int         nwv  = 0;
    logic [7:0] wva [32];
    logic [7:0] wvd [32];
    logic [7:0] dbg_at_wv, dbg_after_wv;
    logic       pend = 1'b0;
    logic       dut_drove = 1'b0;

    always @(negedge clk) begin
        if (wr_valid) begin
            if (nwv < 32) begin
                wva[nwv] = wr_addr;
                wvd[nwv] = wr_data;
            end
            dbg_at_wv = dbg_data;
            pend = 1'b1;
            nwv++;
        end else if (pend) begin
            dbg_after_wv = dbg_data;
            pend = 1'b0;
        end
        if (sda === 1'b0 && !m_low) dut_drove = 1'b1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start();
        m_low = 1'b0; tick(qtr);
        scl = 1'b1;   tick(qtr);
        m_low = 1'b1; tick(qtr);
        scl = 1'b0;   tick(qtr);
    endtask

    task automatic m_stop();
        m_low = 1'b1; tick(qtr);
        scl = 1'b1;   tick(qtr);
        m_low = 1'b0; tick(qtr);
    endtask

    task automatic put_bit(input logic b);
        m_low = ~b; tick(qtr);
        scl = 1'b1; tick(2 * qtr);
        scl = 1'b0; tick(qtr);
    endtask

    task automatic get_bit(output logic b);
        m_low = 1'b0; tick(qtr);
        scl = 1'b1;   tick(qtr);
        b = sda;      tick(qtr);
        scl = 1'b0;   tick(qtr);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic rd_byte(input logic na, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(na);
    endtask

    task automatic dbg_rd(input logic [7:0] a, output logic [7:0] d);
        dbg_addr = a;
        @(negedge clk);
        d = dbg_data;
    endtask

    logic       a0, a1, a2, a3;
    logic [7:0] rd, rd2;
    int         base, waited;

    initial begin
        // Reset state
        tick(5);
        chk("rst_wr_valid", {15'd0, wr_valid}, 16'h0);
        chk("rst_wr_addr", {8'd0, wr_addr}, 16'h0);
        chk("rst_wr_data", {8'd0, wr_data}, 16'h0);
        chk("rst_busy", {15'd0, busy}, 16'h0);
        chk("rst_dbg_data", {8'd0, dbg_data}, 16'h0);
        chk("rst_sda", {15'd0, sda}, 16'h1);
        rstn = 1'b1;
        tick(10);

        // Write 42/12/80 at 100 kHz SCL
        m_start();
        chk("t1_busy", {15'd0, busy}, 16'h1);
        wr_byte(8'h42, a0);
        wr_byte(8'h12, a1);
        wr_byte(8'h80, a2);
        chk("t1_ack", {13'd0, a0, a1, a2}, 16'h0);
        m_stop();
        tick(10);
        chk("t1_busy_stop", {15'd0, busy}, 16'h0);
        chk("t1_nwv", nwv[15:0], 16'd1);
        chk("t1_wv", {wva[0], wvd[0]}, 16'h1280);
        dbg_rd(8'h12, rd);
        chk("t1_dbg", {8'd0, rd}, 16'h0080);

        qtr = 10;

        // Write 3A=04, set pointer, then 2-phase read with NA
        m_start(); wr_byte(8'h42, a0); wr_byte(8'h3A, a1); wr_byte(8'h04, a2); m_stop();
        m_start(); wr_byte(8'h42, a0); wr_byte(8'h3A, a1); m_stop();
        chk("t2_nwv", nwv[15:0], 16'd2);
        m_start(); wr_byte(8'h43, a3);
        rd_byte(1'b1, rd);
        m_stop();
        tick(10);
        chk("t2_rd_ack", {15'd0, a3}, 16'h0);
        chk("t2_rd", {8'd0, rd}, 16'h0004);
        chk("t2_busy", {15'd0, busy}, 16'h0);

        // Wrong ID: no strobe, never drives SDA
        dut_drove = 1'b0;
        m_start(); wr_byte(8'h60, a0); wr_byte(8'h12, a1); wr_byte(8'h55, a2);
        chk("t3_busy_ign", {15'd0, busy}, 16'h1);
        m_stop();
        tick(10);
        chk("t3_ack_none", {13'd0, a0, a1, a2}, 16'h7);
        chk("t3_drove", {15'd0, dut_drove}, 16'h0);
        chk("t3_nwv", nwv[15:0], 16'd2);
        dbg_rd(8'h12, rd);
        chk("t3_mem12", {8'd0, rd}, 16'h0080);

        // Bus write and debug read colliding on 0x12
        dbg_addr = 8'h12;
        m_start(); wr_byte(8'h42, a0); wr_byte(8'h12, a1); wr_byte(8'h5A, a2); m_stop();
        tick(5);
        chk("coll_old", {8'd0, dbg_at_wv}, 16'h0080);
        chk("coll_new", {8'd0, dbg_after_wv}, 16'h005A);

        // Burst with pointer wrap
        base = nwv;
        m_start(); wr_byte(8'h42, a0); wr_byte(8'hFF, a1); wr_byte(8'hAA, a2); wr_byte(8'hBB, a3); m_stop();
        tick(5);
        chk("t4_ack", {12'd0, a0, a1, a2, a3}, 16'h0);
        chk("t4_nwv", nwv[15:0] - base[15:0], 16'd2);
        chk("t4_wv0", {wva[base], wvd[base]}, 16'hFFAA);
        chk("t4_wv1", {wva[base+1], wvd[base+1]}, 16'h00BB);
        dbg_rd(8'hFF, rd);
        dbg_rd(8'h00, rd2);
        chk("t4_dbg", {rd, rd2}, 16'hAABB);

        // Sequential read across the wrap with a master ACK
        m_start(); wr_byte(8'h42, a0); wr_byte(8'hFF, a1); m_stop();
        m_start(); wr_byte(8'h43, a0);
        rd_byte(1'b0, rd);
        rd_byte(1'b1, rd2);
        m_stop();
        chk("t4_seq_rd", {rd, rd2}, 16'hAABB);

        // Repeated START inside the ADDR byte
        base = nwv;
        m_start(); wr_byte(8'h42, a0);
        put_bit(1'b0); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        m_start(); wr_byte(8'h42, a0); wr_byte(8'h20, a1); wr_byte(8'h11, a2); m_stop();
        tick(5);
        chk("t5_nwv", nwv[15:0] - base[15:0], 16'd1);
        chk("t5_wv", {wva[base], wvd[base]}, 16'h2011);
        dbg_rd(8'h20, rd);
        chk("t5_dbg", {8'd0, rd}, 16'h0011);

        // Reset while driving a 0 data bit
        m_start(); wr_byte(8'h42, a0); wr_byte(8'h50, a1); wr_byte(8'h0F, a2); m_stop();
        m_start(); wr_byte(8'h42, a0); wr_byte(8'h50, a1); m_stop();
        m_start(); wr_byte(8'h43, a0);
        m_low = 1'b0;
        waited = 0;
        while (sda !== 1'b0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("t6_drive_low", {15'd0, sda}, 16'h0);
        chk("t6_busy_pre", {15'd0, busy}, 16'h1);
        rstn = 1'b0;
        #1;
        chk("t6_sda_rel", {15'd0, sda}, 16'h1);
        tick(3);
        chk("t6_outs", {13'd0, wr_valid, busy, dbg_data != 8'h00}, 16'h0);
        chk("t6_wr_regs", {wr_addr, wr_data}, 16'h0000);
        rstn = 1'b1;
        tick(5);
        m_stop();
        base = nwv;
        m_start(); wr_byte(8'h42, a0); wr_byte(8'h60, a1); wr_byte(8'h77, a2); m_stop();
        tick(5);
        chk("t6_after_ack", {13'd0, a0, a1, a2}, 16'h0);
        chk("t6_after_wv", {wva[base], wvd[base]}, 16'h6077);
        chk("t6_after_nwv", nwv[15:0] - base[15:0], 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sccb_slave_regfile.md
Name: sccb_slave_regfile

Overview:
- Synthesizable SCCB responder (camera-side end of the OV7670 configuration bus), oversampling SCL/SDA on the system clock.
- Decodes 3-phase writes (ID, sub-address, data) into a 256x8 register file.
- Answers 2-phase reads (ID|1, data) from the last sub-address.
- Used as an on-board camera stand-in for loopback tests of the SCCB init path, and as a bench target; publishes every decoded write on a strobe port.

Parameters:
- DEV_ID, 8'h42: write ID. Read ID is DEV_ID|1. Bit 0 of DEV_ID must be 0.
- SYNC_STAGES, 2: flip-flop stages on the SCL and SDA inputs (minimum 2).
- ACK_EN, 1: 1 = drive SDA low during the 9th bit of accepted write-direction bytes; 0 = leave SDA released (pure SCCB don't-care).

Ports:
- clk  in  1  system clock; must be at least 16x the SCL frequency.
- rstn  in  1  asynchronous active-low reset.
- scl  in  1  SCCB clock from the master.
- sda  inout  1  open-drain data line. The block drives only 1'b0 or 1'bz.
- wr_valid  out  1  one-cycle strobe when a data byte is written.
- wr_addr  out  8  sub-address of the write; valid with wr_valid.
- wr_data  out  8  data byte of the write; valid with wr_valid.
- dbg_addr  in  8  debug read address into the register file.
- dbg_data  out  8  register-file contents at dbg_addr, registered (1-cycle latency).
- busy  out  1  high from START until STOP or abort.

Behaviour:
- Reset (async): state IDLE, SDA released (z), wr_valid=0, wr_addr=0, wr_data=0, busy=0, dbg_data=0, pointer=0. Register-file contents are not reset.
- Synchronize SCL and SDA through SYNC_STAGES flip-flops, then edge-detect on the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Sample data on the SCL rising edge. Change the driven SDA only on the cycle after an SCL falling edge is detected.
- START from any state (repeated START included) -> ID with the bit counter cleared. STOP from any state -> IDLE with SDA released.
- States: IDLE, ID, ID_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, IGNORE.
- ID, 8 bits, MSB first:
  - byte == DEV_ID -> ID_ACK, then ADDR.
  - byte == DEV_ID|1 -> ID_ACK, then RDATA.
  - otherwise -> IGNORE. SDA is never driven in IGNORE; leave it only on START or STOP.
- ID_ACK, ADDR_ACK, WDATA_ACK: pull SDA low if ACK_EN, from the SCL falling edge after bit 0 until the next SCL falling edge, then release.
- ADDR: 8 bits, loaded into the pointer at the 8th rising edge -> ADDR_ACK -> WDATA.
- WDATA: at the 8th rising edge:
  - write mem[pointer].
  - next cycle: wr_valid=1, wr_addr=pointer, wr_data=byte.
  - then WDATA_ACK, pointer+1 (wraps 0xFF -> 0x00), back to WDATA for further bytes.
- RDATA:
  - load the shift register with mem[pointer] on the SCL falling edge that ends ID_ACK.
  - a 0 bit drives SDA low; a 1 bit releases it; advance one bit per SCL falling edge.
  - after 8 bits release SDA -> RD_NA.
- RD_NA: sample the master's bit.
  - 1 (NA) -> IGNORE until STOP.
  - 0 -> pointer+1 (wrap), reload, continue in RDATA.
- A write via the bus and a dbg read of the same address in the same cycle: dbg_data returns the old value; new data is visible one cycle later.
- Reset asserted mid-transaction: SDA is released immediately (combinational from the async reset). A later STOP while in IDLE is harmless.

Decomposition:
- Shared package sccb_pkg holds:
  - state enum.
  - SCCB_WR_ID = 8'h42, SCCB_RD_ID = 8'h43.
  - ACK/NA bit constants.
  - the minimum oversample ratio of 16.
- One sub-module, sccb_line_sync: synchronizer plus edge detector. Outputs scl_rise, scl_fall, start_det, stop_det, and the synchronized sda.

Test Plan:
- Write 42/12/80 at 100 kHz SCL, clk 100 MHz -> wr_valid pulses once with wr_addr=0x12, wr_data=0x80; dbg_addr=0x12 gives 0x80 one cycle later; SDA is low in each of the three 9th bits.
- Write 42/3A/04, then 2-phase 42/3A, STOP, then 43 read -> the master samples 0x04, sends NA=1, STOP; busy=0 after STOP.
- Wrong ID 60/12/55 -> no wr_valid; SDA is never driven; mem[0x12] is unchanged.
- Burst 42/FF/AA/BB -> writes to 0xFF=AA and 0x00=BB (pointer wrap); two wr_valid strobes.
- START inside the ADDR byte after 4 bits, followed by a full 42/20/11 -> only 0x20=0x11 is written.
- rstn pulsed low during RDATA while a 0 bit is being driven -> SDA goes to z in the same cycle; all outputs return to their reset values; the next transaction decodes normally.
